// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and the 3-bit frame-buffer colour expansion.
package vga_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int H_FP         = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BP         = 48;
    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam int V_ACTIVE     = 480;
    localparam int V_FP         = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BP         = 33;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef struct packed {
        logic [2:0] red;
        logic [2:0] green;
        logic [1:0] blue;
    } rgb_t;

    // Each stored colour bit drives its whole connector channel.
    function automatic rgb_t expand_colour(input logic [2:0] c);
        rgb_t rgb;
        rgb.red   = {3{c[2]}};
        rgb.green = {3{c[1]}};
        rgb.blue  = {2{c[0]}};
        return rgb;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider, horizontal/vertical counters and the raw timing flags derived from them.
module vga_timing
    import vga_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       tick,
    output logic       capture,
    output logic [9:0] hc_nxt,
    output logic [9:0] vc_nxt,
    output logic       active,
    output logic       active_nxt,
    output logic       hsync_raw,
    output logic       vsync_raw,
    output logic       vblank_nxt,
    output logic       frame_wrap
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_r;
    logic [9:0]       hc_r;
    logic [9:0]       vc_r;
    logic [9:0]       hc_nxt_s;
    logic [9:0]       vc_nxt_s;
    logic             tick_s;
    logic             line_end_s;
    logic             frame_end_s;

    assign tick_s      = (div_r == DIV_W'(CLK_DIV - 1));
    assign line_end_s  = (hc_r == 10'(H_TOTAL - 1));
    assign frame_end_s = line_end_s && (vc_r == 10'(V_TOTAL - 1));

    // Divider restarts after the tick, so the read data strobe sits a fixed offset into each pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= {DIV_W{1'b0}};
        end else if (tick_s) begin
            div_r <= {DIV_W{1'b0}};
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Next raster position; only moves on a pixel tick.
    always_comb begin
        hc_nxt_s = hc_r;
        vc_nxt_s = vc_r;
        if (tick_s) begin
            if (line_end_s) begin
                hc_nxt_s = 10'd0;
                if (frame_end_s) begin
                    vc_nxt_s = 10'd0;
                end else begin
                    vc_nxt_s = vc_r + 10'd1;
                end
            end else begin
                hc_nxt_s = hc_r + 10'd1;
            end
        end else begin
            hc_nxt_s = hc_r;
            vc_nxt_s = vc_r;
        end
    end

    // Raster position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_r <= 10'd0;
            vc_r <= 10'd0;
        end else begin
            hc_r <= hc_nxt_s;
            vc_r <= vc_nxt_s;
        end
    end

    assign tick       = tick_s;
    assign capture    = (div_r == DIV_W'(READ_LATENCY));
    assign hc_nxt     = hc_nxt_s;
    assign vc_nxt     = vc_nxt_s;
    assign active     = (hc_r < 10'(H_ACTIVE)) && (vc_r < 10'(V_ACTIVE));
    assign active_nxt = (hc_nxt_s < 10'(H_ACTIVE)) && (vc_nxt_s < 10'(V_ACTIVE));
    assign hsync_raw  = !((hc_r >= 10'(H_SYNC_START)) && (hc_r < 10'(H_SYNC_END)));
    assign vsync_raw  = !((vc_r >= 10'(V_SYNC_START)) && (vc_r < 10'(V_SYNC_END)));
    assign vblank_nxt = (vc_nxt_s >= 10'(V_ACTIVE));
    assign frame_wrap = tick_s && frame_end_s;

endmodule

// File: rtl/vga_scanout.sv
// Frame-buffer scanout: issues the read address on entry to each pixel, captures the data
// mid-pixel and registers colour and sync together on the tick that leaves the pixel.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int PX_WIDTH     = 160,
    parameter int PX_HEIGHT    = 120,
    parameter int SCALE        = 4,
    parameter int CLK_DIV      = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] rmemaddr,
    input  logic [2:0]  memo,
    output logic [2:0]  red,
    output logic [2:0]  green,
    output logic [1:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        vblank,
    output logic        frame_start
);

    localparam int SHIFT = $clog2(SCALE);

    if (PX_WIDTH * SCALE != H_ACTIVE || PX_HEIGHT * SCALE != V_ACTIVE ||
        CLK_DIV < READ_LATENCY + 2) begin : g_bad_cfg
        $error("vga_scanout: unsupported geometry or divider");
    end

    logic       tick_s;
    logic       capture_s;
    logic [9:0] hc_nxt_s;
    logic [9:0] vc_nxt_s;
    logic       active_s;
    logic       active_nxt_s;
    logic       hsync_raw_s;
    logic       vsync_raw_s;
    logic       vblank_nxt_s;
    logic       frame_wrap_s;
    logic [15:0] row_s;
    logic [15:0] col_s;
    logic [15:0] addr_s;
    logic [2:0] cap_r;
    rgb_t       pix_s;

    vga_timing #(
        .CLK_DIV      (CLK_DIV),
        .READ_LATENCY (READ_LATENCY)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick_s),
        .capture    (capture_s),
        .hc_nxt     (hc_nxt_s),
        .vc_nxt     (vc_nxt_s),
        .active     (active_s),
        .active_nxt (active_nxt_s),
        .hsync_raw  (hsync_raw_s),
        .vsync_raw  (vsync_raw_s),
        .vblank_nxt (vblank_nxt_s),
        .frame_wrap (frame_wrap_s)
    );

    assign row_s  = 16'(vc_nxt_s >> SHIFT);
    assign col_s  = 16'(hc_nxt_s >> SHIFT);
    assign addr_s = row_s * 16'(PX_WIDTH) + col_s;

    // Address is issued for the pixel being entered; blanking keeps the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rmemaddr <= 16'd0;
        end else if (tick_s && active_nxt_s) begin
            rmemaddr <= addr_s;
        end else begin
            rmemaddr <= rmemaddr;
        end
    end

    // Read data holding register, loaded once the memory latency has elapsed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_r <= 3'd0;
        end else if (capture_s) begin
            cap_r <= memo;
        end else begin
            cap_r <= cap_r;
        end
    end

    // Blank colour outside the visible window.
    always_comb begin
        pix_s = rgb_t'(8'd0);
        if (active_s) begin
            pix_s = expand_colour(cap_r);
        end else begin
            pix_s = rgb_t'(8'd0);
        end
    end

    // Colour and sync share this stage so they stay aligned at the connector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red   <= 3'd0;
            green <= 3'd0;
            blue  <= 2'd0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (tick_s) begin
            red   <= pix_s.red;
            green <= pix_s.green;
            blue  <= pix_s.blue;
            hsync <= hsync_raw_s;
            vsync <= vsync_raw_s;
        end else begin
            red   <= red;
            green <= green;
            blue  <= blue;
            hsync <= hsync;
            vsync <= vsync;
        end
    end

    // Frame status flags for the renderer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vblank      <= vblank_nxt_s;
            frame_start <= frame_wrap_s;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench: two scanouts (read latency 1 and 2) against a raster-arithmetic model, plus pinned points.
module tb_vga_scanout;

    localparam int CD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] addr1, addr2;
    logic [2:0]  memo1, memo2, memo2_p;
    logic [2:0]  r1, g1, r2, g2;
    logic [1:0]  b1, b2;
    logic        hs1, vs1, vb1, fs1, hs2, vs2, vb2, fs2;
    logic [2:0]  mem [0:19199];
    int          checks = 0;
    int          errors = 0;
    int          k = 0;
    bit          run_chk = 1'b0;

    always #5 clk = ~clk;

    vga_scanout #(.READ_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rmemaddr(addr1), .memo(memo1),
        .red(r1), .green(g1), .blue(b1), .hsync(hs1), .vsync(vs1),
        .vblank(vb1), .frame_start(fs1)
    );

    vga_scanout #(.READ_LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .rmemaddr(addr2), .memo(memo2),
        .red(r2), .green(g2), .blue(b2), .hsync(hs2), .vsync(vs2),
        .vblank(vb2), .frame_start(fs2)
    );

    function automatic logic [2:0] rd(input logic [15:0] a);
        if (a < 16'd19200) return mem[a];
        return 3'd0;
    endfunction

    always @(posedge clk) begin
        memo1   <= rd(addr1);
        memo2_p <= rd(addr2);
        memo2   <= memo2_p;
    end

    // Clocks elapsed since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    function automatic int addr_of(input int h, input int v);
        return (v / 4) * 160 + h / 4;
    endfunction

    // Expected {rmemaddr, red, green, blue, hsync, vsync, vblank, frame_start} after clock kk.
    function automatic logic [27:0] model(input int kk, input bit in_rst);
        int pix, h, v, q, qh, qv, a;
        logic [2:0] c;
        logic [2:0] er, eg;
        logic [1:0] eb;
        logic ehs, evs, evb, efs;
        if (in_rst) return {16'd0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        pix = kk / CD;
        h = pix % 800;
        v = (pix / 800) % 525;
        if (v >= 480)      a = addr_of(639, 479);
        else if (h >= 640) a = addr_of(639, v);
        else               a = addr_of(h, v);
        c = 3'd0; ehs = 1'b1; evs = 1'b1;
        if (pix > 0) begin
            q  = pix - 1;
            qh = q % 800;
            qv = (q / 800) % 525;
            if (qh < 640 && qv < 480) c = mem[addr_of(qh, qv)];
            ehs = !(qh >= 656 && qh < 752);
            evs = !(qv >= 490 && qv < 492);
        end
        er  = c[2] ? 3'd7 : 3'd0;
        eg  = c[1] ? 3'd7 : 3'd0;
        eb  = c[0] ? 2'd3 : 2'd0;
        evb = (v >= 480);
        efs = (kk % CD == 0) && (pix > 0) && (pix % 420000 == 0);
        return {16'(a), er, eg, eb, ehs, evs, evb, efs};
    endfunction

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h need %0h (k=%0d)", name, act, req, k);
        end
    endtask

    task automatic wait_k(input int target);
        int guard = 0;
        while (k != target && guard < 60000) begin
            @(negedge clk);
            guard++;
        end
        if (k != target) begin
            checks++;
            errors++;
            $display("FAIL wait_k got %0d need %0d", k, target);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (run_chk) begin
            pin("dut1_cycle", 32'({addr1, r1, g1, b1, hs1, vs1, vb1, fs1}), 32'(model(k, !rst_n)));
            pin("dut2_cycle", 32'({addr2, r2, g2, b2, hs2, vs2, vb2, fs2}), 32'(model(k, !rst_n)));
        end
    end

    initial begin
        int rst_at;
        for (int i = 0; i < 19200; i++) mem[i] = 3'(i % 8);
        #2 rst_n = 1'b0;
        run_chk = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Pinned points with memory = addr % 8; display of pixel (x,y) after clock (y*800+x+1)*4+1.
        wait_k(21);    pin("px4_0_rgb", 32'({r1, g1, b1}), 32'({3'd0, 3'd0, 2'd3}));
        wait_k(37);    pin("px8_0_rgb", 32'({r1, g1, b1}), 32'({3'd0, 3'd7, 2'd0}));
                       pin("px8_0_rgb_l2", 32'({r2, g2, b2}), 32'({3'd0, 3'd7, 2'd0}));
        wait_k(2627);  pin("hs_before_fall", 32'(hs1), 32'd1);
        wait_k(2628);  pin("hs_fall", 32'(hs1), 32'd0);
        wait_k(3011);  pin("hs_before_rise", 32'(hs1), 32'd0);
        wait_k(3012);  pin("hs_rise", 32'(hs1), 32'd1);
        wait_k(5765);  pin("hblank_rgb", 32'({r1, g1, b1}), 32'd0);
        wait_k(5827);  pin("hs_line1_before", 32'(hs1), 32'd1);
        wait_k(5828);  pin("hs_line1_fall", 32'(hs1), 32'd0);
        wait_k(9617);  pin("px3_3_rgb", 32'({r1, g1, b1}), 32'd0);
        wait_k(12161); pin("px639_3_rgb", 32'({r1, g1, b1}), 32'({3'd7, 3'd7, 2'd3}));
        wait_k(12805); pin("px0_4_rgb", 32'({r1, g1, b1}), 32'd0);
                       pin("addr_1_4", 32'(addr1), 32'd160);
                       pin("vblank_low", 32'(vb1), 32'd0);

        // Mid-frame reset near (300,5), off the clock edge.
        rst_at = (5 * 800 + 300) * CD + int'($urandom_range(0, 3));
        wait_k(rst_at);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 pin("rst_async_vals", 32'({addr1, r1, g1, b1, hs1, vs1, vb1, fs1}),
               32'({16'd0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0}));
        for (int i = 0; i < 19200; i++) mem[i] = 3'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        wait_k(2627);  pin("rst_hs_before_fall", 32'({hs1, hs2}), 32'd3);
        wait_k(2628);  pin("rst_hs_fall", 32'({hs1, hs2}), 32'd0);
        wait_k(8 * 3200);
        run_chk = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
